// File: rtl/mono_data_tx_pkg.sv
// Shared definitions for the MONOPIX serial readout emulator.
// Hit word layout is {col, row, le, te}, with the column in the MSBs.
package mono_data_tx_pkg;

  localparam int COL_W      = 6;
  localparam int ROW_W      = 8;
  localparam int TS_W       = 6;
  localparam int WORD_WIDTH = COL_W + ROW_W + 2 * TS_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FROZEN = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_SHIFT  = 2'd3;

  typedef struct packed {
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [TS_W-1:0]  le;
    logic [TS_W-1:0]  te;
  } hit_word_t;

  function automatic logic [TS_W-1:0] bin2gray(input logic [TS_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

endpackage

// File: rtl/mono_data_tx_if.sv
// Hit enqueue bus plus the FREEZE/READ/TOKEN/DATA readout lines of mono_data_tx.
// The master modport is the DAQ / hit source side; the slave modport is the emulated chip.
interface mono_data_tx_if #(
  parameter int WORD_WIDTH = mono_data_tx_pkg::WORD_WIDTH
);

  logic [WORD_WIDTH-1:0] HIT_DATA;
  logic                  HIT_VALID;
  logic                  HIT_READY;
  logic                  FREEZE;
  logic                  READ;
  logic                  TOKEN;
  logic                  DATA;

  modport master (
    output HIT_DATA, HIT_VALID, FREEZE, READ,
    input  HIT_READY, TOKEN, DATA
  );

  modport slave (
    input  HIT_DATA, HIT_VALID, FREEZE, READ,
    output HIT_READY, TOKEN, DATA
  );

endinterface

// File: rtl/mono_data_tx_fifo.sv
// Synchronous hit buffer with occupancy count and a sticky overflow flag.
// Storage is not reset; resetting the pointers discards whatever it holds.
module mono_data_tx_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  rd_pop,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push;
  logic                  pop;

  // count never exceeds DEPTH, so its MSB alone marks the full buffer
  assign wr_ready = ~count_q[ADDR_WIDTH];
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_pop & (count_q != '0);
  assign rd_data  = mem[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_valid & ~wr_ready);
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/mono_data_tx.sv
// Chip-side emulator of the MONOPIX serial readout: FREEZE/READ in, TOKEN/DATA out.
// Define MONO_DATA_TX_GRAY_EN to Gray-code the le/te fields as each word is loaded.
module mono_data_tx #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = mono_data_tx_pkg::WORD_WIDTH
) (
  input  logic              CLK,
  input  logic              nRST,
  mono_data_tx_if.slave     bus,
  output logic [ADDR_WIDTH:0] COUNT,
  output logic              OVERFLOW
);

  import mono_data_tx_pkg::*;

  localparam int              BC_W     = $clog2(WORD_WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic                  freeze_q;
  logic                  read_q;
  logic [ADDR_WIDTH:0]   frz_cnt_q, frz_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  fifo_pop;
  logic [WORD_WIDTH-1:0] head_word;
  logic [WORD_WIDTH-1:0] load_word;
  logic                  freeze_rise;
  logic                  read_rise;

  mono_data_tx_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .wr_data  (bus.HIT_DATA),
    .wr_valid (bus.HIT_VALID),
    .wr_ready (bus.HIT_READY),
    .rd_pop   (fifo_pop),
    .rd_data  (head_word),
    .count    (COUNT),
    .overflow (OVERFLOW)
  );

  assign freeze_rise = bus.FREEZE & ~freeze_q;
  assign read_rise   = bus.READ & ~read_q;

`ifdef MONO_DATA_TX_GRAY_EN
  always_comb begin
    load_word                   = head_word;
    load_word[2*TS_W-1:TS_W]    = bin2gray(head_word[2*TS_W-1:TS_W]);
    load_word[TS_W-1:0]         = bin2gray(head_word[TS_W-1:0]);
  end
`else
  assign load_word = head_word;
`endif

  // Only words present at the freeze are offered; later hits wait for the next freeze
  always_comb begin
    state_d   = state_q;
    frz_cnt_d = frz_cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (freeze_rise) begin
          state_d   = ST_FROZEN;
          frz_cnt_d = COUNT;
        end
      end
      ST_FROZEN: begin
        if (!bus.FREEZE) begin
          state_d = ST_IDLE;
        end else if (read_rise && (frz_cnt_q != '0)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        fifo_pop  = 1'b1;
        shift_d   = load_word;
        frz_cnt_d = frz_cnt_q - (ADDR_WIDTH+1)'(1);
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d = bus.FREEZE ? ST_FROZEN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      freeze_q  <= 1'b0;
      read_q    <= 1'b0;
      frz_cnt_q <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      freeze_q  <= bus.FREEZE;
      read_q    <= bus.READ;
      frz_cnt_q <= frz_cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bus.TOKEN = (state_q == ST_IDLE) ? (COUNT != '0) : (frz_cnt_q != '0);
  assign bus.DATA  = (state_q == ST_SHIFT) & shift_q[WORD_WIDTH-1];

endmodule

// File: tb/tb_mono_data_tx.sv
// Directed self-checking bench for mono_data_tx (ADDR_WIDTH=4, 26-bit words).
// Expected words follow MONO_DATA_TX_GRAY_EN the same way the build does.
module tb_mono_data_tx;

  import mono_data_tx_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [4:0] COUNT;
  logic       OVERFLOW;
  int         compared   = 0;
  int         mismatched = 0;
  logic [25:0] got;

  mono_data_tx_if #(.WORD_WIDTH(26)) bus ();

  mono_data_tx #(
    .ADDR_WIDTH (4),
    .WORD_WIDTH (26)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus.slave),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive every input for one cycle, then settle 1 time unit past the edge
  task automatic applyStimulus(input logic valid, input logic [25:0] data,
                               input logic freeze, input logic read);
    bus.HIT_VALID = valid;
    bus.HIT_DATA  = data;
    bus.FREEZE    = freeze;
    bus.READ      = read;
    @(posedge CLK);
    #1;
  endtask

  // One READ pulse while frozen; optionally pushes a word in the LOAD cycle
  task automatic readWord(output logic [25:0] w, input logic do_push,
                          input logic [25:0] push_data);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b1);
    checkOutput("load_data_low", {31'h0, bus.DATA}, 32'h0);
    applyStimulus(do_push, push_data, 1'b1, 1'b0);
    for (int i = 0; i < 26; i++) begin
      w[25-i] = bus.DATA;
      applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    end
  endtask

  function automatic logic [25:0] txExpect(input logic [25:0] w);
    logic [25:0] r;
    r = w;
`ifdef MONO_DATA_TX_GRAY_EN
    r[11:6] = w[11:6] ^ (w[11:6] >> 1);
    r[5:0]  = w[5:0] ^ (w[5:0] >> 1);
`endif
    return r;
  endfunction

  initial begin
    nRST          = 1'b0;
    bus.HIT_VALID = 1'b0;
    bus.HIT_DATA  = '0;
    bus.FREEZE    = 1'b0;
    bus.READ      = 1'b0;
    #1;
    checkOutput("rst_count", {27'h0, COUNT}, 32'h0);
    checkOutput("rst_ready", {31'h0, bus.HIT_READY}, 32'h1);
    checkOutput("rst_token", {31'h0, bus.TOKEN}, 32'h0);
    checkOutput("rst_data", {31'h0, bus.DATA}, 32'h0);
    checkOutput("rst_ovf", {31'h0, OVERFLOW}, 32'h0);
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    nRST = 1'b1;
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);

    // Single alternating word
    applyStimulus(1'b1, 26'h2AAAAAA, 1'b0, 1'b0);
    checkOutput("idle_token", {31'h0, bus.TOKEN}, 32'h1);
    checkOutput("one_count", {27'h0, COUNT}, 32'h1);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    checkOutput("frozen_token", {31'h0, bus.TOKEN}, 32'h1);
    readWord(got, 1'b0, 26'h0);
`ifdef MONO_DATA_TX_GRAY_EN
    checkOutput("alt_word", {6'h0, got}, 32'h2AAAFFF);
`else
    checkOutput("alt_word", {6'h0, got}, 32'h2AAAAAA);
`endif
    checkOutput("alt_token_after", {31'h0, bus.TOKEN}, 32'h0);
    checkOutput("alt_count_after", {27'h0, COUNT}, 32'h0);
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);

    // Three frozen words, two late arrivals, five READ pulses
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 26'h0ABCDE0 + 26'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 26'h0ABCDE3, 1'b1, 1'b0);
    applyStimulus(1'b1, 26'h0ABCDE4, 1'b1, 1'b0);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    checkOutput("late_count", {27'h0, COUNT}, 32'h5);
    for (int i = 0; i < 3; i++) begin
      readWord(got, 1'b0, 26'h0);
      checkOutput("frz_word", {6'h0, got}, {6'h0, txExpect(26'h0ABCDE0 + 26'(i))});
    end
    checkOutput("late_no_token", {31'h0, bus.TOKEN}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 26'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
      checkOutput("ignored_read_data", {31'h0, bus.DATA}, 32'h0);
      checkOutput("ignored_read_count", {27'h0, COUNT}, 32'h2);
    end
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("unfreeze_token", {31'h0, bus.TOKEN}, 32'h1);
    checkOutput("unfreeze_count", {27'h0, COUNT}, 32'h2);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    for (int i = 3; i < 5; i++) begin
      readWord(got, 1'b0, 26'h0);
      checkOutput("late_word", {6'h0, got}, {6'h0, txExpect(26'h0ABCDE0 + 26'(i))});
    end
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);

    // Timestamp fields: col=1 row=2 le=0x3F te=0x05
    applyStimulus(1'b1, 26'h0102FC5, 1'b0, 1'b0);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    readWord(got, 1'b0, 26'h0);
`ifdef MONO_DATA_TX_GRAY_EN
    checkOutput("le_field", {26'h0, got[11:6]}, 32'h20);
    checkOutput("te_field", {26'h0, got[5:0]}, 32'h07);
`else
    checkOutput("le_field", {26'h0, got[11:6]}, 32'h3F);
    checkOutput("te_field", {26'h0, got[5:0]}, 32'h05);
`endif
    checkOutput("col_row_field", {18'h0, got[25:12]}, 32'h0102);
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a word
    applyStimulus(1'b1, 26'h3FFFFFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 26'h3FFFFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
    checkOutput("midshift_data", {31'h0, bus.DATA}, 32'h1);
    checkOutput("midshift_token", {31'h0, bus.TOKEN}, 32'h1);
    checkOutput("midshift_count", {27'h0, COUNT}, 32'h1);
    nRST = 1'b0;
    #1;
    checkOutput("async_rst_data", {31'h0, bus.DATA}, 32'h0);
    checkOutput("async_rst_token", {31'h0, bus.TOKEN}, 32'h0);
    checkOutput("async_rst_count", {27'h0, COUNT}, 32'h0);
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    nRST = 1'b1;
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);

    // Fill to the brim and beyond
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 26'(i), 1'b0, 1'b0);
    checkOutput("ready_at_15", {31'h0, bus.HIT_READY}, 32'h1);
    applyStimulus(1'b1, 26'h00000F, 1'b0, 1'b0);
    checkOutput("ready_at_16", {31'h0, bus.HIT_READY}, 32'h0);
    checkOutput("count_at_16", {27'h0, COUNT}, 32'h10);
    checkOutput("ovf_at_16", {31'h0, OVERFLOW}, 32'h0);
    applyStimulus(1'b1, 26'h000010, 1'b0, 1'b0);
    checkOutput("count_after_drop", {27'h0, COUNT}, 32'h10);
    checkOutput("ovf_after_drop", {31'h0, OVERFLOW}, 32'h1);
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("ovf_sticky", {31'h0, OVERFLOW}, 32'h1);
    nRST = 1'b0;
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    nRST = 1'b1;
    applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    checkOutput("ovf_cleared", {31'h0, OVERFLOW}, 32'h0);

    // Half-full streaming: a push in every LOAD cycle, across pointer wrap
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 26'h1500000 + 26'(i), 1'b0, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      applyStimulus(1'b0, 26'h0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
        readWord(got, 1'b1, 26'h1500000 + 26'(pass * 8 + k + 8));
        checkOutput("stream_word", {6'h0, got},
                    {6'h0, txExpect(26'h1500000 + 26'(pass * 8 + k))});
        checkOutput("stream_count", {27'h0, COUNT}, 32'h8);
      end
      checkOutput("stream_token", {31'h0, bus.TOKEN}, 32'h0);
      applyStimulus(1'b0, 26'h0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mono_data_tx.md
MONO_DATA_TX -- requirements
Module: mono_data_tx

Purpose: chip-side emulator of the MONOPIX serial readout. It drives TOKEN/DATA in response to FREEZE/READ, for loopback testing of mono_data_rx.

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, giving a hit buffer depth of 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter WORD_WIDTH, default 26, giving the hit word width {col[5:0], row[7:0], le[5:0], te[5:0]}.
REQ-003 CLK  input  1  single clock; all logic is in this domain.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 HIT_DATA  input  26  hit word to enqueue.
REQ-006 HIT_VALID  input  1  enqueue request.
REQ-007 HIT_READY  output  1  buffer not full.
REQ-008 FREEZE  input  1  DAQ freeze level, synchronous to CLK.
REQ-009 READ  input  1  DAQ read strobe, synchronous to CLK.
REQ-010 TOKEN  output  1  hits pending for readout.
REQ-011 DATA  output  1  serial hit data, MSB first.
REQ-012 COUNT  output  ADDR_WIDTH+1  buffer occupancy.
REQ-013 OVERFLOW  output  1  sticky flag: a hit was dropped while full.

Function
REQ-014 A hit SHALL be enqueued when HIT_VALID and HIT_READY are both high; HIT_READY = (COUNT < 2**ADDR_WIDTH).
REQ-015 HIT_VALID while full SHALL drop the word, set OVERFLOW, and leave COUNT unchanged.
REQ-016 The FSM SHALL have the states IDLE, FROZEN, LOAD and SHIFT.
REQ-017 IDLE: TOKEN = (COUNT != 0); a FREEZE rising edge SHALL snapshot COUNT into FRZ_CNT and go to FROZEN.
REQ-018 FROZEN: TOKEN = (FRZ_CNT != 0); hits enqueued during FROZEN SHALL NOT raise TOKEN.
REQ-019 In FROZEN, a READ rising edge with FRZ_CNT != 0 SHALL pop the head word in the next cycle (LOAD), decrement FRZ_CNT, and load the shift register.
REQ-020 A READ rising edge with FRZ_CNT == 0 SHALL be ignored, with no pop.
REQ-021 SHIFT SHALL start on the cycle after LOAD: DATA = shift[25], one bit per CLK, 26 cycles total, then return to FROZEN.
REQ-022 READ edges during LOAD/SHIFT SHALL be ignored.
REQ-023 DATA SHALL be 0 whenever the FSM is not in SHIFT.
REQ-024 FREEZE falling in FROZEN SHALL go to IDLE; FREEZE falling in LOAD/SHIFT SHALL take effect only after the word completes.
REQ-025 A simultaneous push and pop SHALL leave COUNT unchanged; read and write pointers SHALL wrap modulo 2**ADDR_WIDTH.
REQ-026 Latency from READ rising edge to the first DATA bit SHALL be 2 CLK cycles (edge detect, then LOAD).

Reset
REQ-027 nRST low SHALL asynchronously set: state IDLE, pointers 0, COUNT 0, FRZ_CNT 0, TOKEN 0, DATA 0, OVERFLOW 0, HIT_READY 1 (after release).
REQ-028 Reset mid-SHIFT SHALL abort the word; buffer contents are discarded.

Configuration
REQ-029 Macro MONO_DATA_TX_GRAY_EN defined: le and te fields SHALL be converted binary-to-Gray (x ^ (x>>1)) at load time, matching the chip's Gray counters.
REQ-030 MONO_DATA_TX_GRAY_EN undefined: all fields SHALL be transmitted unmodified.

Structure
REQ-031 Package mono_data_tx_pkg SHALL hold the field widths (COL_W=6, ROW_W=8, TS_W=6), WORD_WIDTH=26 and the FSM state enumeration.
REQ-032 The buffer SHALL be a sub-module, mono_data_tx_fifo (synchronous FIFO with COUNT); the FSM and shifter SHALL live in mono_data_tx.

Verification
REQ-033 Push 0x2AAAAAA, FREEZE=1, one READ pulse -> TOKEN=1 before READ; DATA=1,0,1,0... for 26 cycles starting 2 cycles after READ rises; TOKEN=0 afterwards.
REQ-034 Push 3 words, FREEZE, then push 2 more, then 5 READ pulses -> exactly 3 words shifted out; the last 2 READs are ignored; FREEZE falling -> TOKEN=1 with COUNT=2.
REQ-035 Push 17 words with ADDR_WIDTH=4 -> HIT_READY=0 after the 16th; 17th dropped; OVERFLOW=1; COUNT=16.
REQ-036 Deassert nRST at cycle 10 of SHIFT -> DATA=0, TOKEN=0, COUNT=0 immediately, without waiting for a clock edge.
REQ-037 With MONO_DATA_TX_GRAY_EN, push le=0x3F, te=0x05 -> transmitted le=0x20, te=0x07; without the macro -> 0x3F and 0x05.
REQ-038 Continuous push and pop at full rate with the buffer half full -> COUNT stays constant across pointer wrap; output word order is FIFO order.
